// File: rtl/mac_seq_if.sv
// mac_seq_if: job request, operand stream, result handshake and the
// operand/control bundle towards the external multiply-accumulate unit.
interface mac_seq_if #(
    parameter int bw      = 8,
    parameter int psum_bw = 16,
    parameter int len_bw  = 4
);
    // job request
    logic                start;
    logic [len_bw-1:0]   len;
    logic                fmt;

    // operand pair stream
    logic                in_valid;
    logic                in_ready;
    logic [bw-1:0]       in_a;
    logic [bw-1:0]       in_b;

    // external MAC unit
    logic [bw-1:0]       mac_A;
    logic [bw-1:0]       mac_B;
    logic                mac_format;
    logic                mac_acc;
    logic                mac_reset;
    logic [psum_bw-1:0]  mac_out;

    // result handshake and status
    logic                res_valid;
    logic                res_ready;
    logic [psum_bw-1:0]  res_data;
    logic                busy;

    // environment side: issues jobs, supplies operands, models the MAC
    modport master (
        output start, len, fmt, in_valid, in_a, in_b, res_ready, mac_out,
        input  in_ready, mac_A, mac_B, mac_format, mac_acc, mac_reset,
               res_valid, res_data, busy
    );

    // sequencer side
    modport slave (
        input  start, len, fmt, in_valid, in_a, in_b, res_ready, mac_out,
        output in_ready, mac_A, mac_B, mac_format, mac_acc, mac_reset,
               res_valid, res_data, busy
    );
endinterface

// File: rtl/mac_seq.sv
// mac_seq: runs one multiply-accumulate job on an external MAC unit.
// A job clears the MAC for two cycles, streams len operand pairs into it
// (one registered cycle per accepted pair, zero operands on gap cycles),
// lets the MAC pipeline drain, then offers the accumulator as a result.
// The block never interprets operand data; fmt is only forwarded.
module mac_seq #(
    parameter int bw      = 8,
    parameter int psum_bw = 16,
    parameter int len_bw  = 4,
    parameter int drain   = 2
) (
    input  logic     clk,
    input  logic     reset,
    mac_seq_if.slave bus
);
    // Wide enough to hold values up to drain+1.
    localparam int dcnt_bw = $clog2(drain + 2);

    typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, DONE} state_t;

    state_t              state_reg;
    state_t              state_next;
    logic                clr_cnt_reg;
    logic [len_bw-1:0]   rem_reg;
    logic                fmt_reg;
    logic [dcnt_bw-1:0]  dcnt_reg;
    logic [bw-1:0]       mac_a_reg;
    logic [bw-1:0]       mac_b_reg;
    logic [psum_bw-1:0]  res_data_reg;
    logic                accept;
    logic                drain_last;

    // in_ready is high for the whole of STREAM, so acceptance is just valid there
    assign accept = (state_reg == STREAM) && bus.in_valid;

    // DRAIN entered from STREAM starts at 0: its first cycle still carries the
    // last accepted pair, followed by drain zero-operand cycles. Entered
    // straight from CLR (len=0) it starts at 1 and lasts drain cycles.
    assign drain_last = (state_reg == DRAIN) && (dcnt_reg >= dcnt_bw'(drain));

    assign bus.mac_A    = mac_a_reg;
    assign bus.mac_B    = mac_b_reg;
    assign bus.res_data = res_data_reg;

    // state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // next-state logic and state-decoded control outputs
    always_comb begin
        state_next     = state_reg;
        bus.in_ready   = 1'b0;
        bus.mac_acc    = 1'b0;
        bus.mac_reset  = 1'b0;
        bus.res_valid  = 1'b0;
        bus.busy       = (state_reg != IDLE);
        bus.mac_format = (state_reg != IDLE) && fmt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = CLR;
                end
            end
            CLR: begin
                bus.mac_reset = 1'b1;
                if (clr_cnt_reg) begin
                    state_next = (rem_reg == '0) ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                bus.in_ready = 1'b1;
                bus.mac_acc  = 1'b1;
                if (accept && (rem_reg == len_bw'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                bus.mac_acc = 1'b1;
                if (drain_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Keep the MAC cleared for as long as reset is held.
        if (!reset) begin
            bus.mac_reset = 1'b1;
        end
    end

    // job registers, operand pipeline stage and result capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            clr_cnt_reg  <= 1'b0;
            rem_reg      <= '0;
            fmt_reg      <= 1'b0;
            dcnt_reg     <= '0;
            mac_a_reg    <= '0;
            mac_b_reg    <= '0;
            res_data_reg <= '0;
        end else begin
            // Operands are presented exactly one cycle after acceptance;
            // every other cycle feeds zeros so the sum is unaffected.
            mac_a_reg <= accept ? bus.in_a : '0;
            mac_b_reg <= accept ? bus.in_b : '0;
            case (state_reg)
                IDLE: begin
                    clr_cnt_reg <= 1'b0;
                    if (bus.start) begin
                        rem_reg <= bus.len;
                        fmt_reg <= bus.fmt;
                    end
                end
                CLR: begin
                    clr_cnt_reg <= 1'b1;
                    dcnt_reg    <= dcnt_bw'(1);
                end
                STREAM: begin
                    dcnt_reg <= '0;
                    // Counts down to exit, so len=2^len_bw-1 never wraps.
                    if (accept) begin
                        rem_reg <= rem_reg - len_bw'(1);
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        res_data_reg <= bus.mac_out;
                    end else begin
                        dcnt_reg <= dcnt_reg + dcnt_bw'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
